psum_accumulator: RTL and testbench



---
 rtl/bitfusion_pkg.sv | 28 ++
 rtl/psum_sat_add.sv | 37 +++
 rtl/psum_accumulator.sv | 131 +++++++++++++
 tb/tb_psum_accumulator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bitfusion_pkg.sv
// Shared types and helpers for the bit-fusion datapath stages.
// Holds the default psum width, the accumulator state enum and psum_ext().
package bitfusion_pkg;

  localparam int PSUM_W_DEF = 8;
  localparam int EXT_W      = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Extend the low w bits of x to EXT_W, by sign when sgn=1 else by zero.
  function automatic logic [EXT_W-1:0] psum_ext(
    input logic [EXT_W-1:0] x,
    input logic [6:0]       w,
    input logic             sgn
  );
    logic [EXT_W-1:0] hi;
    logic [5:0]       msb;
    hi  = {EXT_W{1'b1}} << w;
    msb = 6'(w - 7'd1);
    if (sgn && x[msb]) psum_ext = x | hi;
    else               psum_ext = x & ~hi;
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// ACC_W adder: wraps by default, saturates when PSUM_ACC_SAT_EN is defined.
// Ports: a, b operands; sum result; (sat build) sat_signed mode, ovf clamp flag.
module psum_sat_add #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
`ifdef PSUM_ACC_SAT_EN
  input  logic             sat_signed,
  output logic             ovf,
`endif
  output logic [ACC_W-1:0] sum
);

`ifdef PSUM_ACC_SAT_EN
  logic [ACC_W:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    if (sat_signed)
      ovf = (a[ACC_W-1] == b[ACC_W-1]) &&
            (raw[ACC_W-1] != a[ACC_W-1]);
    else
      ovf = raw[ACC_W];
    if (!ovf)
      sum = raw[ACC_W-1:0];
    else if (sat_signed)
      sum = b[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                       : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sum = '1;
  end
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates acc_len consecutive psum beats into one ACC_W result on a
// valid/ready output. Optional saturation via PSUM_ACC_SAT_EN.
// Ports: clk, rst (sync, active-high); psum_in/psum_signed/in_valid/in_ready
// beat input; acc_len group length; out_data/out_valid/out_ready result; busy.
module psum_accumulator
  import bitfusion_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              psum_signed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  acc_len,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic             beat;

  assign ext = ACC_W'(psum_ext(EXT_W'(psum_in), 7'(PSUM_W), psum_signed));

`ifdef PSUM_ACC_SAT_EN
  // Mode of the group is fixed by its first beat; sat_q makes a clamp sticky.
  logic sgn_q, sgn_d;
  logic sat_q, sat_d;
  logic ovf;

  psum_sat_add #(.ACC_W(ACC_W)) u_add (
    .a          (acc_q),
    .b          (ext),
    .sat_signed (sgn_q),
    .ovf        (ovf),
    .sum        (sum)
  );
`else
  psum_sat_add #(.ACC_W(ACC_W)) u_add (
    .a   (acc_q),
    .b   (ext),
    .sum (sum)
  );
`endif

  assign in_ready  = (state_q != DRAIN);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign beat      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
`ifdef PSUM_ACC_SAT_EN
    sgn_d   = sgn_q;
    sat_d   = sat_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          len_d = (acc_len == '0) ? CNT_W'(1) : acc_len;
          acc_d = ext;
          cnt_d = CNT_W'(1);
`ifdef PSUM_ACC_SAT_EN
          sgn_d = psum_signed;
          sat_d = 1'b0;
`endif
          state_d = (len_d == CNT_W'(1)) ? DRAIN : ACC;
        end
      end
      ACC: begin
        if (beat) begin
`ifdef PSUM_ACC_SAT_EN
          if (!sat_q) begin
            acc_d = sum;
            sat_d = ovf;
          end
`else
          acc_d = sum;
`endif
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == len_q - CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

`ifdef PSUM_ACC_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      sgn_q <= sgn_d;
      sat_q <= sat_d;
    end
  end
`endif

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a 16-bit and a 10-bit instance
// share the same stimulus; expected values are hand-computed.
module tb_psum_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] psum_in;
  logic       psum_signed;
  logic       in_valid;
  logic [7:0] acc_len;
  logic       out_ready;

  logic        in_ready_a, out_valid_a, busy_a;
  logic [15:0] out_data_a;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [9:0]  out_data_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  psum_accumulator #(.PSUM_W(8), .ACC_W(16), .CNT_W(8)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .psum_in     (psum_in),
    .psum_signed (psum_signed),
    .in_valid    (in_valid),
    .in_ready    (in_ready_a),
    .acc_len     (acc_len),
    .out_data    (out_data_a),
    .out_valid   (out_valid_a),
    .out_ready   (out_ready),
    .busy        (busy_a)
  );

  psum_accumulator #(.PSUM_W(8), .ACC_W(10), .CNT_W(8)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .psum_in     (psum_in),
    .psum_signed (psum_signed),
    .in_valid    (in_valid),
    .in_ready    (in_ready_b),
    .acc_len     (acc_len),
    .out_data    (out_data_b),
    .out_valid   (out_valid_b),
    .out_ready   (out_ready),
    .busy        (busy_b)
  );

  typedef struct {
    logic [7:0]      len;
    logic            sgn;
    int              n;
    logic [4:0][7:0] v;
    logic [15:0]     e16;
    logic [9:0]      e10;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Drive n beats, changing acc_len after the first to prove it is ignored,
  // then check the single-cycle result window.
  task automatic run_group(input string name, input vec_t t);
    out_ready = 1'b1;
    for (int b = 0; b < t.n; b++) begin
      chk({name, "_in_ready"}, 32'(in_ready_a), 32'd1);
      in_valid    = 1'b1;
      psum_in     = t.v[b];
      psum_signed = t.sgn;
      acc_len     = (b == 0) ? t.len : 8'd7;
      @(negedge clk);
      if (b < t.n - 1)
        chk({name, "_early_valid"}, 32'(out_valid_a), 32'd0);
    end
    in_valid = 1'b0;
    chk({name, "_valid"}, 32'(out_valid_a), 32'd1);
    chk({name, "_data16"}, 32'(out_data_a), 32'(t.e16));
    chk({name, "_valid10"}, 32'(out_valid_b), 32'd1);
    chk({name, "_data10"}, 32'(out_data_b), 32'(t.e10));
    chk({name, "_drain_ready"}, 32'(in_ready_a), 32'd0);
    @(negedge clk);
    chk({name, "_valid_drop"}, 32'(out_valid_a), 32'd0);
    chk({name, "_idle"}, 32'(busy_a), 32'd0);
  endtask

  task automatic beat1(input logic [7:0] v, input logic s,
                       input logic [7:0] len);
    in_valid    = 1'b1;
    psum_in     = v;
    psum_signed = s;
    acc_len     = len;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    vec_t g;
    vecs[0] = '{8'd4, 1'b0, 4, {8'd0, 8'd40, 8'd30, 8'd20, 8'd10},
                16'd100, 10'd100};
    vecs[1] = '{8'd3, 1'b1, 3, {8'd0, 8'd0, 8'hFF, 8'hFF, 8'hFF},
                16'hFFFD, 10'h3FD};
    vecs[2] = '{8'd3, 1'b0, 3, {8'd0, 8'd0, 8'hFF, 8'hFF, 8'hFF},
                16'h02FD, 10'h2FD};
    vecs[3] = '{8'd0, 1'b1, 1, {8'd0, 8'd0, 8'd0, 8'd0, 8'h7F},
                16'd127, 10'd127};
    vecs[4] = '{8'd1, 1'b1, 1, {8'd0, 8'd0, 8'd0, 8'd0, 8'h7F},
                16'd127, 10'd127};
`ifdef PSUM_ACC_SAT_EN
    vecs[5] = '{8'd5, 1'b0, 5, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
                16'h04FB, 10'd1023};
    vecs[6] = '{8'd5, 1'b1, 5, {8'h80, 8'h80, 8'h80, 8'h80, 8'h80},
                16'hFD80, 10'h200};
`else
    vecs[5] = '{8'd5, 1'b0, 5, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
                16'h04FB, 10'd251};
    vecs[6] = '{8'd5, 1'b1, 5, {8'h80, 8'h80, 8'h80, 8'h80, 8'h80},
                16'hFD80, 10'h180};
`endif
    vecs[7] = '{8'd2, 1'b0, 2, {8'd0, 8'd0, 8'd0, 8'd100, 8'd200},
                16'd300, 10'd300};

    rst = 1'b1;
    psum_in = '0;
    psum_signed = 1'b0;
    in_valid = 1'b0;
    acc_len = 8'd1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_data", 32'(out_data_a), 32'd0);
    chk("rst_valid", 32'(out_valid_a), 32'd0);
    chk("rst_ready", 32'(in_ready_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);

    for (int i = 0; i < 8; i++)
      run_group($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result held, in_valid ignored while draining.
    out_ready = 1'b0;
    beat1(8'd5, 1'b0, 8'd2);
    beat1(8'd6, 1'b0, 8'd2);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(out_valid_a), 32'd1);
      chk("bp_data", 32'(out_data_a), 32'd11);
      chk("bp_ready", 32'(in_ready_a), 32'd0);
      in_valid = c[0];
      psum_in  = 8'd9;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(out_valid_a), 32'd0);
    chk("bp_idle", 32'(busy_a), 32'd0);
    beat1(8'd3, 1'b0, 8'd1);
    chk("bp_next_data", 32'(out_data_a), 32'd3);
    chk("bp_next_valid", 32'(out_valid_a), 32'd1);
    @(negedge clk);

    // Gap between beats: count and sum hold.
    beat1(8'd7, 1'b0, 8'd2);
    for (int c = 0; c < 3; c++) begin
      chk("gap_valid", 32'(out_valid_a), 32'd0);
      chk("gap_busy", 32'(busy_a), 32'd1);
      @(negedge clk);
    end
    beat1(8'd8, 1'b0, 8'd2);
    chk("gap_valid_end", 32'(out_valid_a), 32'd1);
    chk("gap_data", 32'(out_data_a), 32'd15);
    @(negedge clk);

    // Reset in the middle of a group discards the partial sum.
    beat1(8'd50, 1'b0, 8'd4);
    beat1(8'd60, 1'b0, 8'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ready", 32'(in_ready_a), 32'd1);
    chk("mrst_valid", 32'(out_valid_a), 32'd0);
    chk("mrst_busy", 32'(busy_a), 32'd0);
    g = '{8'd4, 1'b0, 4, {8'd0, 8'd4, 8'd3, 8'd2, 8'd1}, 16'd10, 10'd10};
    run_group("mrst_group", g);

    // Reset while draining drops out_valid.
    out_ready = 1'b0;
    beat1(8'd9, 1'b0, 8'd1);
    chk("drst_pre", 32'(out_valid_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("drst_valid", 32'(out_valid_a), 32'd0);
    chk("drst_ready", 32'(in_ready_a), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
